// File: rtl/vote_link_if.sv
// Link between the vote transmitter and its remote peer.
// The transmitter side is the master (drives cts, ctr, v_out);
// the peer side is the slave (drives rtr, rts, v_in).
interface vote_link_if;
  logic       rtr;
  logic       rts;
  logic [3:0] v_in;
  logic       cts;
  logic       ctr;
  logic [3:0] v_out;

  modport master (input rtr, rts, v_in, output cts, ctr, v_out);
  modport slave  (output rtr, rts, v_in, input cts, ctr, v_out);
endinterface

// File: rtl/vote_link_peer.sv
// Remote peer of the vote transmitter: accepts words over rtr/cts,
// answers each over rts/ctr, and ends the session by returning the
// END code so the transmitter echoes it and returns to standby.
//
//   state    | meaning
//   IDLE     | no session, waiting for go
//   REQ      | rtr high, waiting for cts with a word
//   EVAL     | one cycle: form the reply or detect END
//   WAIT_CTR | reply loaded, waiting for ctr
//   ANSWER   | rts high, waiting for ctr to drop
//   RELEASE  | rtr low, waiting for cts to drop
//   FIN      | END received, waiting for cts to drop
//   ERR      | watchdog expired, waiting for go
module vote_link_peer #(
  parameter int MAX_ROUNDS = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [3:0]       mask,
  vote_link_if.slave       link,
  output logic [3:0]       last_word,
  output logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] REQ      = 3'd1;
  localparam logic [2:0] EVAL     = 3'd2;
  localparam logic [2:0] WAIT_CTR = 3'd3;
  localparam logic [2:0] ANSWER   = 3'd4;
  localparam logic [2:0] RELEASE  = 3'd5;
  localparam logic [2:0] FIN      = 3'd6;
  localparam logic [2:0] ERR      = 3'd7;

  localparam logic [3:0] END_CODE = 4'b0110;
  localparam logic [3:0] SUB_CODE = 4'b1110;

  localparam int RND_W = (MAX_ROUNDS < 2) ? 1 : $clog2(MAX_ROUNDS + 1);
  localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [RND_W-1:0] round;
  logic [WD_W-1:0]  wd;
  logic             waiting;
  logic             wd_expire;
  logic [3:0]       masked;
  logic [3:0]       reply;

  // Watchdog expiry and the masked reply (END is never sent as a data reply)
  always_comb begin
    waiting   = (state == REQ) || (state == WAIT_CTR) || (state == ANSWER) ||
                (state == RELEASE) || (state == FIN);
    wd_expire = (TIMEOUT != 0) && waiting && (wd == WD_W'(TIMEOUT - 1));
    masked    = last_word ^ mask;
    reply     = (masked == END_CODE) ? SUB_CODE : masked;
  end

  // Next-state decode; expiry overrides any handshake progress
  always_comb begin
    state_nxt = state;
    if (wd_expire) begin
      state_nxt = ERR;
    end else begin
      case (state)
        IDLE:     if (go)        state_nxt = REQ;
        REQ:      if (link.cts)  state_nxt = EVAL;
        EVAL:     state_nxt = (last_word == END_CODE) ? FIN : WAIT_CTR;
        WAIT_CTR: if (link.ctr)  state_nxt = ANSWER;
        ANSWER:   if (!link.ctr) state_nxt = RELEASE;
        RELEASE:  if (!link.cts) state_nxt = REQ;
        FIN:      if (!link.cts) state_nxt = IDLE;
        ERR:      if (go)        state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // State register, busy flag and watchdog (cleared on every state change)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE) && (state_nxt != ERR);
      if (TIMEOUT == 0 || !waiting || state_nxt != state)
        wd <= '0;
      else
        wd <= wd + WD_W'(1);
    end
  end

  // Handshake outputs, capture datapath and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      link.rtr   <= 1'b0;
      link.rts   <= 1'b0;
      link.v_in  <= 4'b0000;
      last_word  <= 4'b0000;
      word_count <= '0;
      round      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wd_expire) begin
        link.rtr <= 1'b0;
        link.rts <= 1'b0;
        err      <= 1'b1;
      end else begin
        case (state)
          IDLE: if (go) begin
            round    <= '0;
            link.rtr <= 1'b1;
          end
          REQ: if (link.cts) begin
            last_word <= link.v_out;
            if (word_count != '1) word_count <= word_count + CNT_W'(1);
            if (round < RND_W'(MAX_ROUNDS)) round <= round + RND_W'(1);
          end
          EVAL: begin
            if (last_word == END_CODE)
              link.rtr <= 1'b0;
            else if (round >= RND_W'(MAX_ROUNDS))
              link.v_in <= END_CODE;
            else
              link.v_in <= reply;
          end
          WAIT_CTR: if (link.ctr) link.rts <= 1'b1;
          ANSWER:   if (!link.ctr) link.rtr <= 1'b0;
          RELEASE: if (!link.cts) begin
            link.rts <= 1'b0;
            link.rtr <= 1'b1;
          end
          FIN:     if (!link.cts) done <= 1'b1;
          ERR:     if (go) err <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vote_link_peer.sv
// Bench for vote_link_peer: the bench plays the transmitter side of the
// link, predicts each reply word into a scoreboard queue when the word is
// offered, and compares when the peer raises rts.
module tb_vote_link_peer;

  localparam logic [3:0] END_CODE = 4'b0110;

  logic       clock = 1'b0;
  logic       reset;
  logic       go;
  logic [3:0] mask;
  logic [3:0] last_word;
  logic [1:0] word_count;
  logic       busy;
  logic       done;
  logic       err;

  vote_link_if link();

  vote_link_peer #(.MAX_ROUNDS(2), .TIMEOUT(8), .CNT_W(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .mask       (mask),
    .link       (link),
    .last_word  (last_word),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] word;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[5];
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return link.rtr;
      1:       return link.rts;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic lvl, input string nm);
    int n = 0;
    while (sig(sel) !== lvl && n < 40) begin
      tick();
      n++;
    end
    if (sig(sel) !== lvl) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout %s: level %0b never reached", nm, lvl);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    go         = 1'b0;
    mask       = 4'b0000;
    link.cts   = 1'b0;
    link.ctr   = 1'b0;
    link.v_out = 4'b0000;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pop_compare(input string nm);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: reply %0h with empty scoreboard", nm, link.v_in);
    end else begin
      check(nm, 8'(link.v_in), 8'(exp_q.pop_front()));
    end
  endtask

  // One full word exchange as the transmitter would run it
  task automatic send_word(input logic [3:0] w, input logic [3:0] e);
    wait_sig(0, 1'b1, "rtr_up");
    link.v_out = w;
    link.cts   = 1'b1;
    link.ctr   = 1'b1;
    exp_q.push_back(e);
    wait_sig(1, 1'b1, "rts_up");
    pop_compare("reply");
    link.ctr = 1'b0;
    wait_sig(0, 1'b0, "rtr_down");
    link.cts = 1'b0;
    wait_sig(1, 1'b0, "rts_down");
  endtask

  // Transmitter echoes END; peer must drop rtr and pulse done once
  task automatic send_end();
    int d = 0;
    wait_sig(0, 1'b1, "rtr_up_end");
    link.v_out = END_CODE;
    link.cts   = 1'b1;
    wait_sig(0, 1'b0, "fin_rtr_down");
    check("fin_rts", 8'(link.rts), 8'd0);
    link.cts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) d++;
    end
    check("done_pulses", 8'(d), 8'd1);
    check("idle_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    vecs[0] = '{mask: 4'b0011, word: 4'b0101, exp: 4'b1110};
    vecs[1] = '{mask: 4'b0000, word: 4'b1010, exp: 4'b1010};
    vecs[2] = '{mask: 4'b1111, word: 4'b1001, exp: 4'b1110};
    vecs[3] = '{mask: 4'b1000, word: 4'b0001, exp: 4'b1001};
    vecs[4] = '{mask: 4'b0101, word: 4'b1100, exp: 4'b1001};

    // Reset values
    reset = 1'b1;
    go = 1'b0; mask = 4'b0000;
    link.cts = 1'b0; link.ctr = 1'b0; link.v_out = 4'b0000;
    #1;
    check("rst_rtr", 8'(link.rtr), 8'd0);
    check("rst_rts", 8'(link.rts), 8'd0);
    check("rst_v_in", 8'(link.v_in), 8'd0);
    check("rst_last_word", 8'(last_word), 8'd0);
    check("rst_word_count", 8'(word_count), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_err", 8'(err), 8'd0);

    // Single round with cycle-exact latencies
    do_reset();
    mask = 4'b0001;
    check("pre_go_rtr", 8'(link.rtr), 8'd0);
    pulse_go();
    check("go_rtr", 8'(link.rtr), 8'd1);
    check("go_busy", 8'(busy), 8'd1);
    link.v_out = 4'b0101;
    link.cts   = 1'b1;
    exp_q.push_back(4'b0100);
    tick();
    check("eval_v_in", 8'(link.v_in), 8'd0);
    tick();
    check("v_in_2cyc", 8'(link.v_in), 8'b0100);
    check("wait_rts", 8'(link.rts), 8'd0);
    check("last_word", 8'(last_word), 8'b0101);
    link.ctr = 1'b1;
    tick();
    check("ctr_to_rts", 8'(link.rts), 8'd1);
    pop_compare("single_reply");
    link.ctr = 1'b0;
    tick();
    check("ctr_fall_rtr", 8'(link.rtr), 8'd0);
    link.cts = 1'b0;
    tick();
    check("release_rts", 8'(link.rts), 8'd0);
    check("release_rtr", 8'(link.rtr), 8'd1);
    check("wc_one", 8'(word_count), 8'd1);
    send_end();

    // MAX_ROUNDS=2: second reply is END, transmitter echoes it
    do_reset();
    mask = 4'b0000;
    pulse_go();
    send_word(4'b0001, 4'b0001);
    send_word(4'b0011, END_CODE);
    send_end();
    check("wc_three", 8'(word_count), 8'd3);

    // Table of single-word sessions; word_count saturates at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mask = vecs[i].mask;
      pulse_go();
      send_word(vecs[i].word, vecs[i].exp);
      send_end();
      check("wc_sat", 8'(word_count), (2 * (i + 1) > 3) ? 8'd3 : 8'(2 * (i + 1)));
    end

    // Watchdog: cts never arrives; go while busy ignored
    do_reset();
    pulse_go();
    tick();
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_ignored_busy", 8'(busy), 8'd1);
    check("go_ignored_rtr", 8'(link.rtr), 8'd1);
    for (int i = 0; i < 4; i++) tick();
    check("wd_not_yet", 8'(err), 8'd0);
    tick();
    check("wd_err", 8'(err), 8'd1);
    check("wd_rtr", 8'(link.rtr), 8'd0);
    check("wd_busy", 8'(busy), 8'd0);
    pulse_go();
    check("err_cleared", 8'(err), 8'd0);
    check("err_idle_rtr", 8'(link.rtr), 8'd0);
    pulse_go();
    check("restart_rtr", 8'(link.rtr), 8'd1);

    // Reset while in ANSWER, then a fresh session must start at round 0
    do_reset();
    mask = 4'b0001;
    pulse_go();
    link.v_out = 4'b1010;
    link.cts   = 1'b1;
    link.ctr   = 1'b1;
    wait_sig(1, 1'b1, "rts_before_reset");
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rtr", 8'(link.rtr), 8'd0);
    check("mid_rst_rts", 8'(link.rts), 8'd0);
    check("mid_rst_v_in", 8'(link.v_in), 8'd0);
    check("mid_rst_last", 8'(last_word), 8'd0);
    check("mid_rst_wc", 8'(word_count), 8'd0);
    check("mid_rst_busy", 8'(busy), 8'd0);
    tick();
    link.cts = 1'b0;
    link.ctr = 1'b0;
    reset    = 1'b0;
    tick();
    pulse_go();
    check("post_rst_rtr", 8'(link.rtr), 8'd1);
    send_word(4'b0011, 4'b0010);
    send_end();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
